// File: rtl/ibram_pkg.sv
// Shared constants and state encodings for the input-activation BRAM ping-pong control.
package ibram_pkg;

    localparam int NUM_BANKS  = 8;
    localparam int HALF_DEPTH = 512;

    typedef enum logic [1:0] {
        IDLE,
        INIT_WRITE,
        RUN
    } top_state_t;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        FULL,
        READ
    } half_state_t;

endpackage

// File: rtl/ibram_bank_pp.sv
// One bank's ping-pong bookkeeping: write counter, write/read half pointers,
// per-half fill state and the word count latched when a half closes.
module ibram_bank_pp #(
    parameter int HALF_DEPTH = 512,
    parameter int AW         = $clog2(HALF_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          beat_valid,
    input  logic          close_req,
    input  logic          rd_release,
    output logic          wr_ready,
    output logic          we,
    output logic          wr_half,
    output logic [AW-1:0] wr_addr,
    output logic          rd_avail,
    output logic          rd_half,
    output logic [AW:0]   rd_count
);
    import ibram_pkg::*;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(HALF_DEPTH);

    half_state_t hs_q  [2];
    half_state_t hs_d  [2];
    logic [AW:0] len_q [2];
    logic [AW:0] len_d [2];
    logic [AW:0] cnt_q, cnt_d, cnt_next;
    logic        wp_q, wp_d;
    logic        rp_q, rp_d;

    always_comb begin
        hs_d     = hs_q;
        len_d    = len_q;
        wp_d     = wp_q;
        rp_d     = rp_q;

        wr_ready = (hs_q[wp_q] == EMPTY) || (hs_q[wp_q] == FILL);
        we       = beat_valid & wr_ready;
        wr_addr  = we ? cnt_q[AW-1:0] : '0;
        wr_half  = we & wp_q;
        cnt_next = cnt_q + {{AW{1'b0}}, we};
        cnt_d    = cnt_next;

        if (we) begin
            hs_d[wp_q] = FILL;
        end
        // A beat on the closing cycle is counted before the half is sealed.
        if ((cnt_next == FULL_CNT) || (close_req && (cnt_next != '0))) begin
            hs_d[wp_q]  = FULL;
            len_d[wp_q] = cnt_next;
            wp_d        = ~wp_q;
            cnt_d       = '0;
        end

        rd_avail = (hs_q[rp_q] == FULL) || (hs_q[rp_q] == READ);
        rd_half  = rp_q;
        rd_count = rd_avail ? len_q[rp_q] : '0;

        // Close and release always touch different halves, so both can land together.
        if (rd_avail) begin
            if (rd_release) begin
                hs_d[rp_q] = EMPTY;
                rp_d       = ~rp_q;
            end else begin
                hs_d[rp_q] = READ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q[0]  <= EMPTY;
            hs_q[1]  <= EMPTY;
            len_q[0] <= '0;
            len_q[1] <= '0;
            cnt_q    <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
        end else begin
            hs_q     <= hs_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
        end
    end

endmodule

// File: rtl/ibram_pingpong_ctrl.sv
// Ping-pong controller for the input-activation BRAM array: top FSM, write-source
// ownership and one bookkeeping instance per bank.
module ibram_pingpong_ctrl #(
    parameter int NUM_BANKS  = 8,
    parameter int HALF_DEPTH = 512,
    parameter int AW         = $clog2(HALF_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        init_start,
    input  logic                        wr1_valid,
    input  logic [NUM_BANKS-1:0]        wr1_bank,
    input  logic                        wr1_done,
    output logic                        wr1_ready,
    input  logic [NUM_BANKS-1:0]        wr2_valid,
    input  logic                        wr2_done,
    output logic [NUM_BANKS-1:0]        wr2_ready,
    output logic [NUM_BANKS-1:0]        bram_we,
    output logic [NUM_BANKS-1:0]        bram_wr_half,
    output logic [NUM_BANKS*AW-1:0]     bram_wr_addr,
    output logic [NUM_BANKS-1:0]        rd_avail,
    output logic [NUM_BANKS-1:0]        rd_half,
    output logic [NUM_BANKS*(AW+1)-1:0] rd_count,
    input  logic [NUM_BANKS-1:0]        rd_release,
    output logic                        busy
);
    import ibram_pkg::*;

    // Handshake: a beat transfers in any cycle where valid and ready are both high;
    // ready never depends on valid, and valid may be held while ready is low.

    top_state_t           state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 init_own, run_own, wr1_onehot, wr1_fire, close_req;
    logic [NUM_BANKS-1:0] bank_ready, beat_valid;

    always_comb begin
        init_own   = (state_q == INIT_WRITE);
        run_own    = (state_q == RUN);
        wr1_onehot = (wr1_bank != '0) &&
                     ((wr1_bank & (wr1_bank - NUM_BANKS'(1))) == '0);

        wr1_ready  = init_own & wr1_onehot & (|(bank_ready & wr1_bank));
        wr1_fire   = wr1_valid & wr1_ready;
        wr2_ready  = run_own ? bank_ready : '0;

        if (init_own && wr1_onehot && wr1_valid) begin
            beat_valid = wr1_bank;
        end else if (run_own) begin
            beat_valid = wr2_valid;
        end else begin
            beat_valid = '0;
        end

        // Either done marker seals every bank that holds a partial half.
        close_req = (wr1_fire & wr1_done) | (run_own & wr2_done);

        state_d = state_q;
        case (state_q)
            IDLE:       if (init_start) state_d = INIT_WRITE;
            INIT_WRITE: if (wr1_fire && wr1_done) state_d = RUN;
            RUN:        state_d = RUN;
            default:    state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ibram_bank_pp #(
            .HALF_DEPTH (HALF_DEPTH),
            .AW         (AW)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .beat_valid (beat_valid[b]),
            .close_req  (close_req),
            .rd_release (rd_release[b]),
            .wr_ready   (bank_ready[b]),
            .we         (bram_we[b]),
            .wr_half    (bram_wr_half[b]),
            .wr_addr    (bram_wr_addr[b*AW +: AW]),
            .rd_avail   (rd_avail[b]),
            .rd_half    (rd_half[b]),
            .rd_count   (rd_count[b*(AW+1) +: AW+1])
        );
    end

endmodule

// File: tb/tb_ibram_pingpong_ctrl.sv
// Directed bench for ibram_pingpong_ctrl with hand-computed expectations.
module tb_ibram_pingpong_ctrl;

  localparam int NB = 8;
  localparam int HD = 512;
  localparam int AW = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              init_start;
  logic              wr1_valid;
  logic [NB-1:0]     wr1_bank;
  logic              wr1_done;
  logic              wr1_ready;
  logic [NB-1:0]     wr2_valid;
  logic              wr2_done;
  logic [NB-1:0]     wr2_ready;
  logic [NB-1:0]     bram_we;
  logic [NB-1:0]     bram_wr_half;
  logic [NB*AW-1:0]  bram_wr_addr;
  logic [NB-1:0]     rd_avail;
  logic [NB-1:0]     rd_half;
  logic [NB*(AW+1)-1:0] rd_count;
  logic [NB-1:0]     rd_release;
  logic              busy;

  int checks = 0;
  int errors = 0;

  ibram_pingpong_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .init_start   (init_start),
    .wr1_valid    (wr1_valid),
    .wr1_bank     (wr1_bank),
    .wr1_done     (wr1_done),
    .wr1_ready    (wr1_ready),
    .wr2_valid    (wr2_valid),
    .wr2_done     (wr2_done),
    .wr2_ready    (wr2_ready),
    .bram_we      (bram_we),
    .bram_wr_half (bram_wr_half),
    .bram_wr_addr (bram_wr_addr),
    .rd_avail     (rd_avail),
    .rd_half      (rd_half),
    .rd_count     (rd_count),
    .rd_release   (rd_release),
    .busy         (busy)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int b);
    return 32'(bram_wr_addr[b*AW +: AW]);
  endfunction

  function automatic logic [31:0] cnt_of(input int b);
    return 32'(rd_count[b*(AW+1) +: AW+1]);
  endfunction

  initial begin
    rst = 1'b1; init_start = 1'b0; wr1_valid = 1'b0; wr1_bank = '0; wr1_done = 1'b0;
    wr2_valid = '0; wr2_done = 1'b0; rd_release = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr1_ready", 32'(wr1_ready), 0);
    chk("rst_wr2_ready", 32'(wr2_ready), 0);
    chk("rst_rd_avail", 32'(rd_avail), 0);
    chk("rst_rd_count", 32'(rd_count != '0), 0);
    chk("rst_we", 32'(bram_we), 0);

    // IDLE serves nobody
    wr1_valid = 1'b1; wr1_bank = 8'h01; wr2_valid = 8'hFF;
    #1;
    chk("idle_wr1_ready", 32'(wr1_ready), 0);
    chk("idle_wr2_ready", 32'(wr2_ready), 0);
    chk("idle_we", 32'(bram_we), 0);
    wr1_valid = 1'b0; wr2_valid = '0;

    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    #1;
    chk("init_busy", 32'(busy), 1);

    // illegal bank select and source 2 during init
    wr1_valid = 1'b1; wr1_bank = 8'b0000_0101; wr2_valid = 8'h04;
    #1;
    chk("illegal_wr1_ready", 32'(wr1_ready), 0);
    chk("illegal_we", 32'(bram_we), 0);
    chk("init_wr2_ready", 32'(wr2_ready), 0);
    tick();
    wr2_valid = '0;

    // full initial load of bank 0, done on the last beat
    for (int i = 0; i < HD; i++) begin
      wr1_bank = 8'h01; wr1_done = (i == HD - 1);
      #1;
      chk("init_we", 32'(bram_we), 32'h01);
      chk("init_addr", addr_of(0), 32'(i));
      chk("init_half", 32'(bram_wr_half[0]), 0);
      tick();
    end
    wr1_done = 1'b0;
    #1;
    chk("load_rd_avail", 32'(rd_avail), 32'h01);
    chk("load_rd_count0", cnt_of(0), 512);
    chk("load_rd_half0", 32'(rd_half[0]), 0);
    chk("run_wr1_ready", 32'(wr1_ready), 0);
    chk("run_wr1_we", 32'(bram_we), 0);
    chk("run_busy", 32'(busy), 1);
    wr1_valid = 1'b0;

    // init_start in RUN is ignored
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    #1;
    chk("run_restart_busy", 32'(busy), 1);
    chk("run_restart_rd_avail", 32'(rd_avail), 32'h01);
    chk("run_wr2_ready", 32'(wr2_ready), 32'hFF);

    // partial close of bank 3
    for (int i = 0; i < 5; i++) begin
      wr2_valid = 8'h08;
      #1;
      chk("part_we", 32'(bram_we), 32'h08);
      chk("part_addr", addr_of(3), 32'(i));
      chk("part_half", 32'(bram_wr_half[3]), 0);
      tick();
    end
    wr2_valid = '0; wr2_done = 1'b1;
    tick();
    wr2_done = 1'b0;
    #1;
    chk("part_rd_avail", 32'(rd_avail), 32'h09);
    chk("part_rd_count3", cnt_of(3), 5);
    chk("part_rd_half3", 32'(rd_half[3]), 0);
    wr2_valid = 8'h08;
    #1;
    chk("part_next_addr", addr_of(3), 0);
    chk("part_next_half", 32'(bram_wr_half[3]), 1);
    tick();
    wr2_valid = '0;

    // back-pressure on bank 2
    for (int i = 0; i < 2 * HD; i++) begin
      wr2_valid = 8'h04;
      #1;
      chk("bp_addr", addr_of(2), 32'(i % HD));
      chk("bp_half", 32'(bram_wr_half[2]), 32'(i / HD));
      tick();
    end
    #1;
    chk("bp_ready", 32'(wr2_ready[2]), 0);
    chk("bp_we", 32'(bram_we), 0);
    chk("bp_rd_avail2", 32'(rd_avail[2]), 1);
    chk("bp_rd_half2", 32'(rd_half[2]), 0);
    chk("bp_rd_count2", cnt_of(2), 512);
    rd_release = 8'h04;
    tick();
    rd_release = '0;
    #1;
    chk("rel_ready", 32'(wr2_ready[2]), 1);
    chk("rel_we", 32'(bram_we), 32'h04);
    chk("rel_addr", addr_of(2), 0);
    chk("rel_half", 32'(bram_wr_half[2]), 0);
    chk("rel_rd_half2", 32'(rd_half[2]), 1);
    chk("rel_rd_count2", cnt_of(2), 512);
    tick();
    wr2_valid = '0;

    // bank 1: close of half 1 coincides with release of half 0
    for (int i = 0; i < 2 * HD; i++) begin
      wr2_valid = 8'h02;
      if (i == 2 * HD - 1) begin
        rd_release = 8'h02;
      end
      #1;
      chk("sim_addr", addr_of(1), 32'(i % HD));
      chk("sim_half", 32'(bram_wr_half[1]), 32'(i / HD));
      if (i == 2 * HD - 1) begin
        chk("sim_pre_rd_half1", 32'(rd_half[1]), 0);
      end
      tick();
    end
    rd_release = '0;
    #1;
    chk("sim_rd_avail1", 32'(rd_avail[1]), 1);
    chk("sim_rd_half1", 32'(rd_half[1]), 1);
    chk("sim_rd_count1", cnt_of(1), 512);
    chk("sim_ready1", 32'(wr2_ready[1]), 1);
    chk("sim_addr_next", addr_of(1), 0);
    chk("sim_half_next", 32'(bram_wr_half[1]), 0);
    wr2_valid = '0;

    // reset in the middle of a fill
    for (int i = 0; i < 100; i++) begin
      wr2_valid = 8'h10;
      #1;
      chk("mid_addr", addr_of(4), 32'(i));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rd_avail", 32'(rd_avail), 0);
    chk("mid_rst_rd_count", 32'(rd_count != '0), 0);
    chk("mid_rst_rd_half", 32'(rd_half), 0);
    chk("mid_rst_wr2_ready", 32'(wr2_ready), 0);
    chk("mid_rst_we", 32'(bram_we), 0);
    wr2_valid = '0;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    wr1_valid = 1'b1; wr1_bank = 8'h10;
    #1;
    chk("restart_wr1_ready", 32'(wr1_ready), 1);
    chk("restart_we", 32'(bram_we), 32'h10);
    chk("restart_addr", addr_of(4), 0);
    chk("restart_half", 32'(bram_wr_half[4]), 0);
    tick();
    wr1_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibram_pingpong_ctrl.md
# ibram_pingpong_ctrl

Per-bank ping-pong controller for the input-activation BRAM array. It owns the write address counters, the write/read half pointers and the fill state of both halves of every bank. It arbitrates between the streaming initial loader (source 1) and the per-bank runtime writer (source 2). It hands complete halves to the read controller and takes them back when released. It sits between the two activation write controllers and the read controller, and drives the port-A controls and half-select of the BRAM array.

## Interface
- `NUM_BANKS`, 8: number of banks; each bank is two BRAM halves (ping/pong).
- `HALF_DEPTH`, 512: words per half; `AW = $clog2(HALF_DEPTH)`.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `init_start` in 1: pulse; begins an initial load.
- `wr1_valid` in 1: source-1 beat valid.
- `wr1_bank` in NUM_BANKS: one-hot target bank of the source-1 beat.
- `wr1_done` in 1: source-1 final beat marker, qualified with `wr1_valid`.
- `wr1_ready` out 1: source-1 beat accepted.
- `wr2_valid` in NUM_BANKS: per-bank source-2 beat valid.
- `wr2_done` in 1: closes all open source-2 halves.
- `wr2_ready` out NUM_BANKS: per-bank accept.
- `bram_we` out NUM_BANKS: per-bank port-A write strobe.
- `bram_wr_half` out NUM_BANKS: half written (0 = ping).
- `bram_wr_addr` out NUM_BANKS×AW: per-bank write address.
- `rd_avail` out NUM_BANKS: a FULL half is ready for reading.
- `rd_half` out NUM_BANKS: half the reader must use.
- `rd_count` out NUM_BANKS×(AW+1): valid words in that half.
- `rd_release` in NUM_BANKS: reader finished the current half.
- `busy` out 1: top FSM is not IDLE.

## Operation
- Top FSM states: IDLE, INIT_WRITE, RUN.
  - IDLE→INIT_WRITE on `init_start`.
  - INIT_WRITE→RUN on an accepted beat with `wr1_done`.
  - RUN remains until `rst`. `init_start` outside IDLE is ignored.
- Source ownership:
  - Only source 1 is served in INIT_WRITE; only source 2 is served in RUN.
  - The non-owning source has ready=0.
  - In IDLE both readies are 0.
- Per-half state (2 bits): EMPTY, FILL, FULL, READ.
  - Write pointer `wp[b]` selects the half being filled; read pointer `rp[b]` selects the half being read.
- Beat acceptance, bank b:
  - Requires the target half `wp[b]` to be EMPTY or FILL.
  - Source-1 `wr1_ready` = owner & the half of the selected bank is writable. `wr1_bank` with ≠1 bit set is never accepted; `wr1_ready` stays 0.
  - On accept: `bram_we[b]`=1, `bram_wr_addr[b]`=cnt[b], `bram_wr_half[b]`=wp[b]. The half becomes FILL and cnt[b] increments.
- Half close: when cnt[b] reaches HALF_DEPTH (beat at address HALF_DEPTH-1), or on done with cnt[b]>0:
  - The half becomes FULL and its count is latched.
  - wp[b] toggles and cnt[b] resets to 0.
  - Done with cnt[b]=0 closes nothing.
  - `wr1_done` closes every bank with an open half; `wr2_done` likewise.
- Read side:
  - `rd_avail[b]`=1 when half `rp[b]` is FULL or READ; that half is then marked READ.
  - `rd_release[b]` while READ: the half becomes EMPTY and rp[b] toggles.
  - `rd_release` with nothing in READ is ignored.
- Full condition: both halves FULL/READ means the bank's ready=0 (back-pressure); no data is dropped.
- Simultaneous events on the same bank:
  - Close of one half and release of the other half both take effect in the same cycle.
  - A beat accepted on the closing cycle writes the last address and then closes.

## Timing
- `bram_we`, `bram_wr_addr`, `bram_wr_half` and the readies are combinational from the current state and valids; the datapath registers the data alongside.
- Counters, pointers, half states and FSM update on the next rising edge.
- A half closed at edge N shows `rd_avail`=1 in cycle N+1 (one-cycle latency).
- A released half becomes writable in the cycle after `rd_release`.
- Throughput: one beat per bank per cycle.
- Reset values:
  - FSM IDLE; all halves EMPTY; cnt, wp, rp = 0.
  - All outputs 0, including `busy` and `rd_count`.
- Reset mid-operation discards all partial and full halves; BRAM contents are not cleared.

## Structure
- Shared package `ibram_pkg`:
  - `NUM_BANKS`, `HALF_DEPTH`.
  - State enums `top_state_t` {IDLE, INIT_WRITE, RUN} and `half_state_t` {EMPTY, FILL, FULL, READ}.
- One sub-module `ibram_bank_pp`, instantiated NUM_BANKS times from a generate loop, holds per-bank cnt, wp, rp, two half states and two latched counts.
- The top level holds the FSM and source muxing.

## Test plan
- Init load, NUM_BANKS=8, HALF_DEPTH=512: 512 beats to bank 0 via source 1, then `wr1_done` → bank 0 half 0 FULL, `rd_avail[0]`=1 next cycle, `rd_count[0]`=512, `rd_half[0]`=0, FSM RUN.
- Partial close: 5 beats to bank 3, then `wr2_done` → `rd_count[3]`=5, addresses 0..4 on half 0, next beat goes to half 1 at addr 0.
- Back-pressure: fill both halves of bank 2 without release → `wr2_ready[2]`=0. Then `rd_release[2]` → ready=1 the following cycle, write goes to half 0 at addr 0.
- Simultaneous: a bank 1 close edge coinciding with `rd_release[1]` on the other half → both halves transition, `rd_half[1]` toggles, no lost state.
- Illegal and ignored inputs: `wr1_bank`=8'b0000_0101 → no `bram_we`; `wr2_valid` during INIT_WRITE → `wr2_ready`=0; `init_start` in RUN → no change.
- Reset mid-fill: `rst` after 100 beats → all outputs 0 next cycle, then `init_start` restarts at addr 0, half 0.
